// File: rtl/seq_mult_nxn.sv
// Sequential A_W x A_W multiplier built around a single DIG_W x DIG_W partial multiplier.
// A control FSM walks every digit pair, shift-accumulates the partial products, then applies the sign.
module seq_mult_nxn #(
   parameter int A_W   = 8,
   parameter int DIG_W = 4
) (
   input  logic               clk,
   input  logic               reset_a,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [A_W-1:0]     data_a,
   input  logic [A_W-1:0]     data_b,
   output logic [2*A_W-1:0]   product,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         state_out
);

   localparam int N_DIG  = A_W / DIG_W;
   localparam int N_STEP = N_DIG * N_DIG;
   localparam int CNT_W  = $clog2(N_STEP);
   localparam int P_W    = 2 * A_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEP - 1);

   generate
      if (A_W % DIG_W != 0) begin : g_bad_width
         $error("seq_mult_nxn: A_W must be a multiple of DIG_W");
      end
      if (N_DIG < 2) begin : g_bad_digits
         $error("seq_mult_nxn: A_W/DIG_W must be at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [A_W-1:0]     a_mag, b_mag;
   logic               neg;
   logic [P_W-1:0]     acc;
   logic [CNT_W-1:0]   count;

   // Most-negative input wraps to 2^(A_W-1), which is still correct as an unsigned magnitude.
   function automatic logic [A_W-1:0] magnitude(input logic [A_W-1:0] v, input logic sgn);
      return (sgn && v[A_W-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [P_W-1:0] partial_term(input logic [A_W-1:0] a,
                                                   input logic [A_W-1:0] b,
                                                   input logic [CNT_W-1:0] cnt);
      int                 i, j;
      logic [DIG_W-1:0]   da, db;
      logic [2*DIG_W-1:0] pp;
      i  = int'(cnt) / N_DIG;
      j  = int'(cnt) % N_DIG;
      da = DIG_W'(a >> (i * DIG_W));
      db = DIG_W'(b >> (j * DIG_W));
      pp = {{DIG_W{1'b0}}, da} * {{DIG_W{1'b0}}, db};
      return P_W'(pp) << ((i + j) * DIG_W);
   endfunction

   function automatic logic [P_W-1:0] apply_sign(input logic [P_W-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   always_ff @(posedge clk) begin
      if (reset_a) state <= IDLE;
      else         state <= state_nxt;
   end

   // Any start request restarts the calculation, whether it is a fresh job or an abort.
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? CALC : IDLE;
         CALC:    state_nxt = start ? CALC : ((count == LAST) ? FIX : CALC);
         FIX:     state_nxt = start ? CALC : DONE;
         DONE:    state_nxt = start ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == CALC) || (state == FIX);
      done      = (state == DONE);
      state_out = state;
   end

   always_ff @(posedge clk) begin
      if (reset_a) begin
         product <= '0;
         err     <= 1'b0;
         acc     <= '0;
         count   <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         neg     <= 1'b0;
      end else if (start) begin
         a_mag <= magnitude(data_a, signed_mode);
         b_mag <= magnitude(data_b, signed_mode);
         neg   <= signed_mode & (data_a[A_W-1] ^ data_b[A_W-1]);
         acc   <= '0;
         count <= '0;
         err   <= (state == CALC) || (state == FIX);
      end else begin
         case (state)
            CALC: begin
               acc   <= acc + partial_term(a_mag, b_mag, count);
               count <= (count == LAST) ? '0 : count + 1'b1;
            end
            FIX:     product <= apply_sign(acc, neg);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_nxn.sv
// Bench for seq_mult_nxn: an 8x8 (4-bit digit) and a 16x16 (4-bit digit) instance,
// table vectors, randomized jobs against an arithmetic model, and abort/reset sequences.
module tb_seq_mult_nxn;

   logic        clk = 1'b0;
   logic        reset_a;
   logic        start8, sg8, busy8, done8, err8;
   logic [7:0]  a8, b8;
   logic [15:0] prod8;
   logic [1:0]  st8;
   logic        start16, sg16, busy16, done16, err16;
   logic [15:0] a16, b16;
   logic [31:0] prod16;
   logic [1:0]  st16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_mult_nxn #(.A_W(8), .DIG_W(4)) dut8 (
      .clk(clk), .reset_a(reset_a), .start(start8), .signed_mode(sg8),
      .data_a(a8), .data_b(b8), .product(prod8), .busy(busy8), .done(done8),
      .err(err8), .state_out(st8));

   seq_mult_nxn #(.A_W(16), .DIG_W(4)) dut16 (
      .clk(clk), .reset_a(reset_a), .start(start16), .signed_mode(sg16),
      .data_a(a16), .data_b(b16), .product(prod16), .busy(busy16), .done(done16),
      .err(err16), .state_out(st16));

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        s;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[8];

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint sa, sb;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      return 16'(sa * sb);
   endfunction

   function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
      longint sa, sb;
      sa = s ? longint'($signed(a)) : longint'(a);
      sb = s ? longint'($signed(b)) : longint'(b);
      return 32'(sa * sb);
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_done8(output logic [15:0] p, output int lat, output int nbusy);
      lat = 0; p = '0; nbusy = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (busy8) nbusy++;
         if (done8) begin
            chk("busy_done_excl8", 64'(busy8), 64'd0);
            lat = k;
            p   = prod8;
            break;
         end
      end
   endtask

   task automatic job8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       output logic [15:0] p, output int lat, output int nbusy);
      @(posedge clk); #1;
      start8 = 1'b1; a8 = a; b8 = b; sg8 = s;
      @(posedge clk); #1;
      start8 = 1'b0;
      wait_done8(p, lat, nbusy);
   endtask

   task automatic job16(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output logic [31:0] p, output int lat, output int nbusy);
      @(posedge clk); #1;
      start16 = 1'b1; a16 = a; b16 = b; sg16 = s;
      @(posedge clk); #1;
      start16 = 1'b0;
      lat = 0; p = '0; nbusy = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (busy16) nbusy++;
         if (done16) begin
            lat = k;
            p   = prod16;
            break;
         end
      end
   endtask

   initial begin
      logic [15:0] p8, prev8;
      logic [31:0] p16;
      logic [7:0]  ra, rb;
      logic [15:0] ra16, rb16;
      logic        rs;
      int          lat, nbusy, ndone;

      tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
      tbl[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
      tbl[2] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1};
      tbl[3] = '{8'hFD, 8'h05, 1'b0, 16'h04F1};
      tbl[4] = '{8'h00, 8'hA5, 1'b0, 16'h0000};
      tbl[5] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
      tbl[6] = '{8'h00, 8'hFB, 1'b1, 16'h0000};
      tbl[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};

      reset_a = 1'b1;
      start8 = 1'b0; sg8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;
      repeat (3) @(posedge clk);
      #1 reset_a = 1'b0;
      @(negedge clk);
      chk("rst_state", 64'(st8), 64'd0);
      chk("rst_product", 64'(prod8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_err", 64'(err8), 64'd0);
      chk("rst_product16", 64'(prod16), 64'd0);

      for (int v = 0; v < 8; v++) begin
         job8(tbl[v].a, tbl[v].b, tbl[v].s, p8, lat, nbusy);
         chk($sformatf("tbl%0d_product", v), 64'(p8), 64'(tbl[v].exp));
         chk($sformatf("tbl%0d_latency", v), 64'(lat), 64'd6);
         chk($sformatf("tbl%0d_busy_cycles", v), 64'(nbusy), 64'd5);
      end

      for (int r = 0; r < 20; r++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         job8(ra, rb, rs, p8, lat, nbusy);
         chk($sformatf("rand%0d_product", r), 64'(p8), 64'(model8(ra, rb, rs)));
         chk($sformatf("rand%0d_latency", r), 64'(lat), 64'd6);
      end

      // start presented while in DONE is a normal acceptance
      start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sg8 = 1'b0;
      @(posedge clk); #1 start8 = 1'b0;
      @(negedge clk);
      chk("done_start_state", 64'(st8), 64'd1);
      chk("done_start_err", 64'(err8), 64'd0);
      wait_done8(p8, lat, nbusy);
      chk("done_start_product", 64'(p8), 64'h03A8);
      chk("done_start_latency", 64'(lat), 64'd5);

      // abort in the second CALC cycle
      prev8 = prod8;
      @(posedge clk); #1;
      start8 = 1'b1; a8 = 8'h55; b8 = 8'h66; sg8 = 1'b0;
      @(posedge clk); #1 start8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b1; a8 = 8'h03; b8 = 8'h04;
      @(posedge clk); #1 start8 = 1'b0;
      @(negedge clk);
      chk("abort_err", 64'(err8), 64'd1);
      chk("abort_product_held", 64'(prod8), 64'(prev8));
      chk("abort_state", 64'(st8), 64'd1);
      ndone = 0; lat = 0; p8 = '0;
      for (int k = 2; k <= 25; k++) begin
         @(negedge clk);
         if (done8) begin
            ndone++;
            lat = k;
            p8  = prod8;
         end
      end
      chk("abort_done_count", 64'(ndone), 64'd1);
      chk("abort_latency", 64'(lat), 64'd6);
      chk("abort_product", 64'(p8), 64'h000C);
      chk("abort_err_sticky", 64'(err8), 64'd1);
      job8(8'h02, 8'h03, 1'b0, p8, lat, nbusy);
      chk("err_cleared", 64'(err8), 64'd0);
      chk("after_abort_product", 64'(p8), 64'h0006);

      // reset in the middle of CALC
      @(posedge clk); #1;
      start8 = 1'b1; a8 = 8'h0F; b8 = 8'h0F; sg8 = 1'b0;
      @(posedge clk); #1 start8 = 1'b0;
      @(posedge clk); #1 reset_a = 1'b1;
      @(posedge clk); #1 reset_a = 1'b0;
      @(negedge clk);
      chk("midrst_state", 64'(st8), 64'd0);
      chk("midrst_product", 64'(prod8), 64'd0);
      chk("midrst_busy", 64'(busy8), 64'd0);
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      chk("midrst_no_done", 64'(ndone), 64'd0);

      job16(16'hFFFF, 16'hFFFF, 1'b0, p16, lat, nbusy);
      chk("w16_ffff_product", 64'(p16), 64'hFFFE0001);
      chk("w16_ffff_latency", 64'(lat), 64'd18);
      chk("w16_ffff_busy_cycles", 64'(nbusy), 64'd17);
      job16(16'h8000, 16'h0001, 1'b1, p16, lat, nbusy);
      chk("w16_neg_product", 64'(p16), 64'hFFFF8000);
      job16(16'h8000, 16'h8000, 1'b1, p16, lat, nbusy);
      chk("w16_minmin_product", 64'(p16), 64'h40000000);
      for (int r = 0; r < 6; r++) begin
         ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'($urandom);
         job16(ra16, rb16, rs, p16, lat, nbusy);
         chk($sformatf("w16_rand%0d_product", r), 64'(p16), 64'(model16(ra16, rb16, rs)));
         chk($sformatf("w16_rand%0d_latency", r), 64'(lat), 64'd18);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
